// File: rtl/mem_access_unit.sv
// Memory stage: byte/half/word loads and stores over a valid/addr_ok/data_ok bus.
// Optional MEM_UNALIGNED_EXC_EN: misaligned accesses retire as address errors.
module mem_access_unit #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 32,
   parameter int REG_W  = 5
) (
   input  logic                clk,
   input  logic                resetn,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [31:0]         in_pc,
   input  logic [3:0]          in_op,
   input  logic [ADDR_W-1:0]   in_addr,
   input  logic [DATA_W-1:0]   in_wdata,
   input  logic [DATA_W-1:0]   in_alu,
   input  logic [REG_W-1:0]    in_regw,
   output logic                dreq_valid,
   output logic [ADDR_W-1:0]   dreq_addr,
   output logic [2:0]          dreq_size,
   output logic [DATA_W/8-1:0] dreq_strobe,
   output logic [DATA_W-1:0]   dreq_data,
   input  logic                dresp_addr_ok,
   input  logic                dresp_data_ok,
   input  logic [DATA_W-1:0]   dresp_data,
   output logic                out_valid,
   output logic [31:0]         out_pc,
   output logic [REG_W-1:0]    out_regw,
   output logic                out_wen,
   output logic [DATA_W-1:0]   out_wdata,
   output logic                out_exc
);

   localparam int NB = DATA_W / 8;
   localparam int L  = $clog2(NB);

   typedef enum logic [1:0] {
      S_IDLE,
      S_REQ,
      S_WAIT
   } state_t;

   state_t state;

   logic              is_mem;
   logic              is_store;
   logic              is_signed;
   logic [1:0]        size;
   logic [ADDR_W-1:0] req_addr;
   logic [L-1:0]      lane;
   logic [NB-1:0]     bmask;
   logic [NB-1:0]     strobe;
   logic [DATA_W-1:0] wmask;
   logic [DATA_W-1:0] sdata;

   logic              r_store;
   logic              r_signed;
   logic [1:0]        r_size;
   logic [L-1:0]      r_lane;

   logic [DATA_W-1:0] sh;
   logic [DATA_W-1:0] ld;
   logic              done;
   logic              unused_sh;

   always_comb begin
      is_mem    = 1'b1;
      is_store  = 1'b0;
      is_signed = 1'b0;
      size      = 2'd0;
      unique case (in_op)
         4'd1: is_signed = 1'b1;
         4'd2: is_signed = 1'b0;
         4'd3: begin
            size      = 2'd1;
            is_signed = 1'b1;
         end
         4'd4: size = 2'd1;
         4'd5: begin
            size      = 2'd2;
            is_signed = 1'b1;
         end
         4'd6: size = 2'd2;
         4'd7: is_store = 1'b1;
         4'd8: begin
            size     = 2'd1;
            is_store = 1'b1;
         end
         4'd9: begin
            size     = 2'd2;
            is_store = 1'b1;
         end
         default: is_mem = 1'b0;
      endcase
   end

   // Misaligned addresses are pulled down to the access size.
   always_comb begin
      req_addr = in_addr;
      unique case (size)
         2'd1: req_addr[0] = 1'b0;
         2'd2: req_addr[1:0] = 2'b00;
         default: req_addr = in_addr;
      endcase
      lane = req_addr[L-1:0];
   end

   always_comb begin
      unique case (size)
         2'd0: begin
            bmask = NB'(1);
            wmask = DATA_W'(64'hFF);
         end
         2'd1: begin
            bmask = NB'(3);
            wmask = DATA_W'(64'hFFFF);
         end
         default: begin
            bmask = NB'(15);
            wmask = DATA_W'(64'hFFFF_FFFF);
         end
      endcase
      strobe = is_store ? (bmask << lane) : '0;
      sdata  = (in_wdata & wmask) << {lane, 3'b000};
   end

`ifdef MEM_UNALIGNED_EXC_EN
   logic misalign;
   logic exc_q;

   always_comb begin
      unique case (size)
         2'd1: misalign = in_addr[0];
         2'd2: misalign = |in_addr[1:0];
         default: misalign = 1'b0;
      endcase
   end

   assign out_exc = exc_q;
`else
   assign out_exc = 1'b0;
`endif

   // The extra top bit carries the sign only for signed loads.
   always_comb begin
      sh = dresp_data >> {r_lane, 3'b000};
      unique case (r_size)
         2'd0: ld = DATA_W'($signed({r_signed & sh[7], sh[7:0]}));
         2'd1: ld = DATA_W'($signed({r_signed & sh[15], sh[15:0]}));
         default: ld = DATA_W'($signed({r_signed & sh[31], sh[31:0]}));
      endcase
   end

   assign unused_sh = ^sh;
   assign in_ready  = (state == S_IDLE);
   assign done      = dresp_data_ok &
                      ((state == S_WAIT) |
                       ((state == S_REQ) & dresp_addr_ok));

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state       <= S_IDLE;
         dreq_valid  <= 1'b0;
         dreq_addr   <= '0;
         dreq_size   <= '0;
         dreq_strobe <= '0;
         dreq_data   <= '0;
         out_valid   <= 1'b0;
         out_pc      <= '0;
         out_regw    <= '0;
         out_wen     <= 1'b0;
         out_wdata   <= '0;
         r_store     <= 1'b0;
         r_signed    <= 1'b0;
         r_size      <= '0;
         r_lane      <= '0;
`ifdef MEM_UNALIGNED_EXC_EN
         exc_q       <= 1'b0;
`endif
      end else begin
         out_valid <= 1'b0;
`ifdef MEM_UNALIGNED_EXC_EN
         exc_q     <= 1'b0;
`endif
         unique case (state)
            S_IDLE: begin
               if (in_valid) begin
                  out_pc   <= in_pc;
                  out_regw <= in_regw;
                  if (!is_mem) begin
                     out_valid <= 1'b1;
                     out_wen   <= |in_regw;
                     out_wdata <= in_alu;
`ifdef MEM_UNALIGNED_EXC_EN
                  end else if (misalign) begin
                     out_valid <= 1'b1;
                     exc_q     <= 1'b1;
                     out_wen   <= 1'b0;
                     out_wdata <= DATA_W'(in_addr);
`endif
                  end else begin
                     state       <= S_REQ;
                     dreq_valid  <= 1'b1;
                     dreq_addr   <= req_addr;
                     dreq_size   <= {1'b0, size};
                     dreq_strobe <= strobe;
                     dreq_data   <= sdata;
                     r_store     <= is_store;
                     r_signed    <= is_signed;
                     r_size      <= size;
                     r_lane      <= lane;
                  end
               end
            end
            S_REQ: begin
               if (dresp_addr_ok) begin
                  dreq_valid <= 1'b0;
                  if (!dresp_data_ok) begin
                     state <= S_WAIT;
                  end
               end
            end
            S_WAIT: state <= S_WAIT;
            default: state <= S_IDLE;
         endcase
         if (done) begin
            state     <= S_IDLE;
            out_valid <= 1'b1;
            out_wen   <= ~r_store & (|out_regw);
            out_wdata <= r_store ? '0 : ld;
         end
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized bench for mem_access_unit against an arithmetic reference model.
// Honours MEM_UNALIGNED_EXC_EN when the build defines it.
module tb_mem_access_unit;

`ifdef MEM_UNALIGNED_EXC_EN
   localparam bit EXC_EN = 1'b1;
`else
   localparam bit EXC_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_pc = '0;
   logic [3:0]  in_op = '0;
   logic [31:0] in_addr = '0;
   logic [31:0] in_wdata = '0;
   logic [31:0] in_alu = '0;
   logic [4:0]  in_regw = '0;
   logic        dreq_valid;
   logic [31:0] dreq_addr;
   logic [2:0]  dreq_size;
   logic [3:0]  dreq_strobe;
   logic [31:0] dreq_data;
   logic        dresp_addr_ok = 1'b0;
   logic        dresp_data_ok = 1'b0;
   logic [31:0] dresp_data = '0;
   logic        out_valid;
   logic [31:0] out_pc;
   logic [4:0]  out_regw;
   logic        out_wen;
   logic [31:0] out_wdata;
   logic        out_exc;

   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   mem_access_unit dut (
      .clk(clk), .resetn(resetn),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_pc(in_pc), .in_op(in_op), .in_addr(in_addr),
      .in_wdata(in_wdata), .in_alu(in_alu), .in_regw(in_regw),
      .dreq_valid(dreq_valid), .dreq_addr(dreq_addr),
      .dreq_size(dreq_size), .dreq_strobe(dreq_strobe),
      .dreq_data(dreq_data), .dresp_addr_ok(dresp_addr_ok),
      .dresp_data_ok(dresp_data_ok), .dresp_data(dresp_data),
      .out_valid(out_valid), .out_pc(out_pc), .out_regw(out_regw),
      .out_wen(out_wen), .out_wdata(out_wdata), .out_exc(out_exc)
   );

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic int nbytes(input logic [3:0] op);
      case (op)
         4'd1, 4'd2, 4'd7: return 1;
         4'd3, 4'd4, 4'd8: return 2;
         4'd5, 4'd6, 4'd9: return 4;
         default: return 0;
      endcase
   endfunction

   function automatic logic [31:0] load_val(input logic [3:0] op,
                                            input logic [31:0] addr,
                                            input logic [31:0] raw);
      int n = nbytes(op);
      longint unsigned a = addr;
      longint unsigned v = raw;
      int lane;
      a = a - a % n;
      lane = int'(a % 4);
      v = (v >> (8 * lane)) % (64'd1 << (8 * n));
      if ((op == 4'd1 || op == 4'd3 || op == 4'd5) &&
          v >= (64'd1 << (8 * n - 1)))
         v = v + (64'd1 << 32) - (64'd1 << (8 * n));
      return v[31:0];
   endfunction

   task automatic run_op(input logic [3:0] op, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] alu,
                         input logic [4:0] regw, input logic [31:0] raw,
                         input int aok_dly, input int dok_dly);
      int n = nbytes(op);
      bit mem = (n != 0);
      bit st = (op >= 4'd7 && op <= 4'd9);
      bit mis = mem && (addr % n != 0);
      bit exc_exp = mis && EXC_EN;
      logic [31:0] pc = $urandom;
      longint unsigned ea;
      longint unsigned ed;
      int lane;
      logic [3:0] estrb;
      ea = 0; ed = 0; lane = 0; estrb = '0;
      if (mem) begin
         ea = addr;
         ea = ea - ea % n;
         lane = int'(ea % 4);
         estrb = 4'(((1 << n) - 1) << lane);
         ed = wdata;
         ed = (ed % (64'd1 << (8 * n))) << (8 * lane);
      end
      @(negedge clk);
      chk("idle_ready", in_ready, 1);
      chk("out_pulse_end", out_valid, 0);
      in_valid = 1'b1; in_op = op; in_addr = addr; in_wdata = wdata;
      in_alu = alu; in_regw = regw; in_pc = pc;
      @(negedge clk);
      in_valid = 1'b0; in_op = 4'($urandom); in_addr = $urandom;
      in_wdata = $urandom; in_alu = $urandom; in_regw = 5'($urandom);
      in_pc = $urandom;
      if (!mem || exc_exp) begin
         chk("no_req", dreq_valid, 0);
         chk("out_valid", out_valid, 1);
         chk("out_pc", out_pc, pc);
         chk("out_regw", out_regw, regw);
         chk("out_exc", out_exc, exc_exp);
         chk("out_ready", in_ready, 1);
         if (exc_exp) begin
            chk("exc_wen", out_wen, 0);
            chk("exc_wdata", out_wdata, addr);
         end else begin
            chk("alu_wen", out_wen, regw != 0);
            chk("alu_wdata", out_wdata, alu);
         end
      end else begin
         for (int i = 0; i <= aok_dly; i++) begin
            chk("req_valid", dreq_valid, 1);
            chk("req_ready", in_ready, 0);
            chk("req_out", out_valid, 0);
            chk("req_addr", dreq_addr, ea[31:0]);
            chk("req_size", dreq_size, (n == 1) ? 0 : (n == 2) ? 1 : 2);
            chk("req_strobe", dreq_strobe, st ? estrb : 4'b0);
            if (st) chk("req_data", dreq_data, ed[31:0]);
            dresp_addr_ok = (i == aok_dly);
            dresp_data_ok = (i == aok_dly) && (dok_dly == 0);
            dresp_data = dresp_data_ok ? raw : $urandom;
            @(negedge clk);
         end
         for (int i = 0; i < dok_dly; i++) begin
            chk("wait_valid", dreq_valid, 0);
            chk("wait_ready", in_ready, 0);
            chk("wait_out", out_valid, 0);
            dresp_addr_ok = 1'($urandom);
            dresp_data_ok = (i == dok_dly - 1);
            dresp_data = dresp_data_ok ? raw : $urandom;
            @(negedge clk);
         end
         dresp_addr_ok = 1'b0; dresp_data_ok = 1'b0;
         dresp_data = $urandom;
         chk("done_valid", out_valid, 1);
         chk("done_ready", in_ready, 1);
         chk("done_req", dreq_valid, 0);
         chk("done_pc", out_pc, pc);
         chk("done_regw", out_regw, regw);
         chk("done_exc", out_exc, 0);
         chk("done_wen", out_wen, st ? 1'b0 : (regw != 0));
         if (!st) chk("load_data", out_wdata, load_val(op, addr, raw));
      end
   endtask

   initial begin
      #12;
      chk("rst_ready", in_ready, 1);
      chk("rst_dvalid", dreq_valid, 0);
      chk("rst_daddr", dreq_addr, 0);
      chk("rst_strobe", dreq_strobe, 0);
      chk("rst_ovalid", out_valid, 0);
      chk("rst_wdata", out_wdata, 0);
      chk("rst_wen", out_wen, 0);
      chk("rst_exc", out_exc, 0);
      @(negedge clk);
      resetn = 1'b1;

      run_op(4'd0, 32'h0, 32'h0, 32'h1234, 5'd3, 32'h0, 0, 0);
      run_op(4'd0, 32'h0, 32'h0, 32'h1234, 5'd0, 32'h0, 0, 0);
      run_op(4'd1, 32'h103, 32'h0, 32'h0, 5'd4, 32'h80FF_0000, 2, 1);
      run_op(4'd2, 32'h103, 32'h0, 32'h0, 5'd4, 32'h80FF_0000, 2, 1);
      run_op(4'd8, 32'h202, 32'hABCD, 32'h0, 5'd7, 32'h0, 0, 1);
      run_op(4'd5, 32'h40, 32'h0, 32'h0, 5'd9, 32'hDEAD_BEEF, 0, 0);
      run_op(4'd5, 32'h41, 32'h0, 32'h0, 5'd9, 32'hDEAD_BEEF, 1, 0);
      run_op(4'd12, 32'h41, 32'h0, 32'h5555, 5'd2, 32'h0, 0, 0);

      // two pass-through ops issued in consecutive cycles
      @(negedge clk);
      in_valid = 1'b1; in_op = 4'd0; in_alu = 32'hAAAA; in_regw = 5'd1;
      @(negedge clk);
      in_alu = 32'hBBBB; in_regw = 5'd2;
      chk("b2b_first", out_wdata, 32'hAAAA);
      chk("b2b_ready", in_ready, 1);
      @(negedge clk);
      in_valid = 1'b0;
      chk("b2b_valid", out_valid, 1);
      chk("b2b_second", out_wdata, 32'hBBBB);
      chk("b2b_regw", out_regw, 2);

      // reset while waiting for data
      @(negedge clk);
      in_valid = 1'b1; in_op = 4'd5; in_addr = 32'h80; in_regw = 5'd6;
      @(negedge clk);
      in_valid = 1'b0; dresp_addr_ok = 1'b1;
      @(negedge clk);
      dresp_addr_ok = 1'b0;
      chk("wait_busy", in_ready, 0);
      #2 resetn = 1'b0;
      #1;
      chk("arst_dvalid", dreq_valid, 0);
      chk("arst_ovalid", out_valid, 0);
      chk("arst_ready", in_ready, 1);
      @(negedge clk);
      resetn = 1'b1;
      dresp_data_ok = 1'b1; dresp_data = 32'h1234_5678;
      @(negedge clk);
      dresp_data_ok = 1'b0;
      chk("stray_out", out_valid, 0);
      chk("stray_req", dreq_valid, 0);
      chk("stray_ready", in_ready, 1);

      for (int k = 0; k < 300; k++) begin
         logic [31:0] a;
         a = $urandom;
         if (k % 2 == 0) a = a & 32'hFFFF_FFF8;
         if (k % 4 == 0) a = a | 32'($urandom_range(0, 3));
         run_op(4'($urandom_range(0, 15)), a, $urandom, $urandom,
                5'($urandom), $urandom, $urandom_range(0, 3),
                $urandom_range(0, 3));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Memory stage for the pipelined CPU, sitting between the execute/memory pipeline register and the write-back register.
- Accepts one instruction at a time and issues byte, halfword or word loads and stores on the data bus.
- Holds the bus request until the address handshake, waits for the data handshake, and stalls upstream while busy.
- Aligns store data and strobes, sign- or zero-extends load data, and passes non-memory results through in one cycle.

Parameters:
- DATA_W, 32, data bus and register width; legal values 32 or 64.
- ADDR_W, 32, address width.
- REG_W, 5, destination register index width.

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- in_valid  in  1  upstream instruction valid
- in_ready  out  1  unit can accept; equals (state==IDLE)
- in_pc  in  32  instruction PC
- in_op  in  4  0=NONE 1=LB 2=LBU 3=LH 4=LHU 5=LW 6=LWU 7=SB 8=SH 9=SW; other codes behave as NONE
- in_addr  in  ADDR_W  effective address
- in_wdata  in  DATA_W  store data
- in_alu  in  DATA_W  pass-through result for NONE
- in_regw  in  REG_W  destination register
- dreq_valid  out  1  bus request valid
- dreq_addr  out  ADDR_W  request address
- dreq_size  out  3  0=1B 1=2B 2=4B
- dreq_strobe  out  DATA_W/8  byte write enables; 0 for loads
- dreq_data  out  DATA_W  lane-aligned store data
- dresp_addr_ok  in  1  request accepted
- dresp_data_ok  in  1  transfer complete
- dresp_data  in  DATA_W  raw read data
- out_valid  out  1  one-cycle result pulse to write-back
- out_pc  out  32  PC of retiring instruction
- out_regw  out  REG_W  destination register
- out_wen  out  1  register write enable
- out_wdata  out  DATA_W  write-back value
- out_exc  out  1  address-error flag

Behaviour:
- Reset: state=IDLE. All outputs 0, except in_ready=1.
- States: IDLE, REQ, WAIT.
- IDLE, in_valid=1, non-memory op:
  - Registers inputs; next cycle out_valid=1, out_wdata=in_alu, out_wen=(in_regw!=0).
  - Stays in IDLE, so back-to-back issue gives 1 result per cycle.
- IDLE, in_valid=1, aligned memory op: latch fields, go to REQ.
- Alignment rule, with L=log2(DATA_W/8):
  - Halfword requires addr[0]=0.
  - Word requires addr[1:0]=0.
  - Byte lane = addr[L-1:0].
- REQ: dreq_valid=1. All dreq fields are driven from registers and held stable until dresp_addr_ok.
  - addr_ok=1 with data_ok=0: go to WAIT, dreq_valid=0 next cycle.
  - addr_ok=1 with data_ok=1: complete directly.
- WAIT: dreq_valid=0; on data_ok=1, complete.
- Completion: next cycle out_valid=1 and state=IDLE.
- Stores: out_wen=0.
  - strobe = size mask shifted by lane (SB addr 0x...2 gives 4'b0100).
  - dreq_data = in_wdata low bytes shifted left by 8*lane.
- Loads:
  - Raw data is shifted right by 8*lane.
  - LB/LH/LW sign-extend to DATA_W; LBU/LHU/LWU zero-extend.
  - LW and LWU are identical when DATA_W=32.
  - out_wen=(regw!=0).
- dresp_data is sampled only in the data_ok cycle.
- data_ok is ignored unless state is REQ or WAIT. addr_ok is ignored outside REQ.
- Reset asserted mid-transaction: immediate return to IDLE, dreq_valid=0, nothing retires. The bus must be reset together with this unit.
- in_ready=0 in REQ and WAIT; upstream holds its register.

Optional Feature:
- Macro MEM_UNALIGNED_EXC_EN.
- Defined: a misaligned load or store issues no bus request. Next cycle out_valid=1, out_exc=1, out_wen=0, out_wdata=in_addr zero-extended (bad address). Stays in IDLE.
- Undefined: out_exc is tied 0. Misaligned addresses are aligned down to the access size and the access proceeds normally.

Test Plan:
- NONE, in_alu=0x1234, regw=3 -> next cycle out_valid=1, out_wdata=0x1234, out_wen=1. Repeat with regw=0 -> out_wen=0.
- LB addr=0x103, addr_ok delayed 2 cycles, data_ok 1 cycle later, dresp_data=0x80FF_0000 -> dreq fields stable for 3 cycles, out_wdata=0xFFFF_FF80. LBU at the same address -> 0x0000_0080.
- SH addr=0x202, wdata=0xABCD -> dreq_strobe=4'b1100, dreq_data=0xABCD_0000, size=1, out_wen=0.
- LW addr=0x40 with addr_ok and data_ok in the same cycle, dresp_data=0xDEAD_BEEF -> out_valid exactly 1 cycle later, in_ready low for exactly 1 cycle.
- LW addr=0x41 with MEM_UNALIGNED_EXC_EN -> dreq_valid never asserted, out_exc=1, out_wdata=0x41. Without the macro -> dreq_addr=0x40.
- resetn low during WAIT -> dreq_valid=0, out_valid=0, in_ready=1 immediately. A stray data_ok after release -> no output.
